// File: rtl/cpu_ctrl_pkg.sv
// Shared pipeline-control definitions used by the hazard sequencer,
// the forwarding logic and the decoder.
package cpu_ctrl_pkg;

    // Mul/div occupancy sequencer states
    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

    // Architectural zero register index; writes to it never create hazards
    localparam int unsigned REG_ZERO = 0;

endpackage

// File: rtl/hazard_compare.sv
// Load-use hazard detection: a load in EX whose destination is read by ID.
module hazard_compare #(
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_uses_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_mem_read,
    output logic                  load_use
);
    import cpu_ctrl_pkg::*;

    // Compare the load destination against the live source operands of ID
    always_comb begin
        load_use = ex_mem_read
                 && (ex_rd != REG_ADDR_W'(REG_ZERO))
                 && ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use stalls, mul/div
// occupancy of EX, branch flushes, data-memory wait states with a watchdog,
// and a saturating stall-cycle counter.
module pipeline_hazard_ctrl #(
    parameter int unsigned REG_ADDR_W  = 5,
    parameter int unsigned MD_CYCLES   = 8,
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned PERF_W      = 32
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_uses_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_mem_read,
    input  logic                  ex_muldiv,
    input  logic                  branch_taken_ex,
    input  logic                  mem_access,
    input  logic                  dmem_ready,
    output logic                  pc_write_en,
    output logic                  ifid_write_en,
    output logic                  idex_write_en,
    output logic                  exmem_write_en,
    output logic                  ifid_flush,
    output logic                  idex_bubble,
    output logic                  exmem_bubble,
    output logic                  memwb_bubble,
    output logic                  md_start,
    output logic                  md_done,
    output logic                  mem_timeout_err,
    output logic [PERF_W-1:0]     stall_cycles
);
    import cpu_ctrl_pkg::*;

    localparam int unsigned MD_CNT_W = (MD_CYCLES > 2) ? $clog2(MD_CYCLES) : 1;
    localparam int unsigned WAIT_W   = $clog2(MEM_TIMEOUT + 1);
    localparam logic [MD_CNT_W-1:0] MD_LOAD  = MD_CNT_W'(MD_CYCLES - 1);
    localparam logic [WAIT_W-1:0]   WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

    md_state_e           state;
    logic [MD_CNT_W-1:0] md_cnt;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [WAIT_W-1:0]   wait_nxt;
    logic                load_use;
    logic                mem_freeze;
    logic                md_hold;

    hazard_compare #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_cmp (
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_uses_rs2 (id_uses_rs2),
        .ex_rd       (ex_rd),
        .ex_mem_read (ex_mem_read),
        .load_use    (load_use)
    );

    // Hazard conditions derived from state and inputs
    always_comb begin
        mem_freeze = mem_access & ~dmem_ready;
        md_hold    = ((state == RUN) && ex_muldiv) || ((state == MD_BUSY) && (md_cnt != '0));
        wait_nxt   = wait_cnt;
        if (!mem_freeze)
            wait_nxt = '0;
        else if (wait_cnt != WAIT_MAX)
            wait_nxt = wait_cnt + 1'b1;
    end

    // Prioritised stage controls: freeze, mul/div hold, branch flush, load-use
    always_comb begin
        pc_write_en    = 1'b1;
        ifid_write_en  = 1'b1;
        idex_write_en  = 1'b1;
        exmem_write_en = 1'b1;
        ifid_flush     = 1'b0;
        idex_bubble    = 1'b0;
        exmem_bubble   = 1'b0;
        memwb_bubble   = 1'b0;
        md_start       = 1'b0;
        md_done        = ((state == MD_BUSY) && (md_cnt == '0)) || (state == MD_DONE);
        if (mem_freeze) begin
            pc_write_en    = 1'b0;
            ifid_write_en  = 1'b0;
            idex_write_en  = 1'b0;
            exmem_write_en = 1'b0;
            memwb_bubble   = 1'b1;
        end else if (md_hold) begin
            pc_write_en   = 1'b0;
            ifid_write_en = 1'b0;
            idex_write_en = 1'b0;
            exmem_bubble  = 1'b1;
            md_start      = (state == RUN);
        end else if (branch_taken_ex) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (load_use) begin
            pc_write_en   = 1'b0;
            ifid_write_en = 1'b0;
            idex_bubble   = 1'b1;
        end
    end

    // Mul/div occupancy sequencer; the countdown keeps running under a freeze
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state  <= RUN;
            md_cnt <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (ex_muldiv && !mem_freeze) begin
                        state  <= MD_BUSY;
                        md_cnt <= MD_LOAD;
                    end
                end
                MD_BUSY: begin
                    if (md_cnt == '0)
                        state <= mem_freeze ? MD_DONE : RUN;
                    else
                        md_cnt <= md_cnt - 1'b1;
                end
                MD_DONE: begin
                    if (!mem_freeze)
                        state <= RUN;
                end
                default: state <= RUN;
            endcase
        end
    end

    // Memory-wait watchdog; the flag latches as the run length reaches the limit
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wait_cnt        <= '0;
            mem_timeout_err <= 1'b0;
        end else begin
            wait_cnt <= wait_nxt;
            if (mem_freeze && (wait_nxt == WAIT_MAX))
                mem_timeout_err <= 1'b1;
        end
    end

    // Saturating count of cycles in which the PC is held
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n)
            stall_cycles <= '0;
        else if (!pc_write_en && (stall_cycles != '1))
            stall_cycles <= stall_cycles + 1'b1;
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: a cycle-level reference model
// plus directed scenarios with literal expectations.
module tb_pipeline_hazard_ctrl;

    localparam int MDC = 8;
    localparam int TMO = 4;
    localparam int PW  = 4;
    localparam int STALL_MAX = (1 << PW) - 1;

    logic          clk = 1'b0;
    logic          arst_n;
    logic [4:0]    id_rs1, id_rs2, ex_rd;
    logic          id_uses_rs2, ex_mem_read, ex_muldiv, branch_taken_ex, mem_access, dmem_ready;
    logic          pc_write_en, ifid_write_en, idex_write_en, exmem_write_en;
    logic          ifid_flush, idex_bubble, exmem_bubble, memwb_bubble;
    logic          md_start, md_done, mem_timeout_err;
    logic [PW-1:0] stall_cycles;

    int checks = 0;
    int errors = 0;

    pipeline_hazard_ctrl #(
        .REG_ADDR_W  (5),
        .MD_CYCLES   (MDC),
        .MEM_TIMEOUT (TMO),
        .PERF_W      (PW)
    ) dut (
        .clk             (clk),
        .arst_n          (arst_n),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_uses_rs2     (id_uses_rs2),
        .ex_rd           (ex_rd),
        .ex_mem_read     (ex_mem_read),
        .ex_muldiv       (ex_muldiv),
        .branch_taken_ex (branch_taken_ex),
        .mem_access      (mem_access),
        .dmem_ready      (dmem_ready),
        .pc_write_en     (pc_write_en),
        .ifid_write_en   (ifid_write_en),
        .idex_write_en   (idex_write_en),
        .exmem_write_en  (exmem_write_en),
        .ifid_flush      (ifid_flush),
        .idex_bubble     (idex_bubble),
        .exmem_bubble    (exmem_bubble),
        .memwb_bubble    (memwb_bubble),
        .md_start        (md_start),
        .md_done         (md_done),
        .mem_timeout_err (mem_timeout_err),
        .stall_cycles    (stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a mul/div op is tracked by its age since issue
    bit m_active, n_active;
    int m_age, n_age, m_run, n_run, m_stall, n_stall;
    bit m_err, n_err;
    bit frz, hz, busy, ready_now;
    bit e_pc, e_ifid, e_idex, e_exmem, e_flush, e_idb, e_exb, e_mwb, e_start, e_done;

    always @(negedge arst_n) begin
        m_active = 0; m_age = 0; m_run = 0; m_err = 0; m_stall = 0;
    end

    always @(negedge clk) begin
        frz       = mem_access && !dmem_ready;
        hz        = ex_mem_read && (ex_rd != 0) &&
                    ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));
        ready_now = m_active && (m_age >= MDC);
        busy      = m_active ? (m_age < MDC) : ex_muldiv;
        {e_pc, e_ifid, e_idex, e_exmem} = 4'b1111;
        {e_flush, e_idb, e_exb, e_mwb, e_start} = 5'b0;
        e_done = ready_now;
        if (frz) begin
            {e_pc, e_ifid, e_idex, e_exmem} = 4'b0000;
            e_mwb = 1;
        end else if (busy) begin
            {e_pc, e_ifid, e_idex} = 3'b000;
            e_exb   = 1;
            e_start = !m_active;
        end else if (branch_taken_ex) begin
            e_flush = 1; e_idb = 1;
        end else if (hz) begin
            e_pc = 0; e_ifid = 0; e_idb = 1;
        end
        check("pc_write_en", 32'(pc_write_en), 32'(e_pc));
        check("ifid_write_en", 32'(ifid_write_en), 32'(e_ifid));
        check("idex_write_en", 32'(idex_write_en), 32'(e_idex));
        check("exmem_write_en", 32'(exmem_write_en), 32'(e_exmem));
        check("ifid_flush", 32'(ifid_flush), 32'(e_flush));
        check("idex_bubble", 32'(idex_bubble), 32'(e_idb));
        check("exmem_bubble", 32'(exmem_bubble), 32'(e_exb));
        check("memwb_bubble", 32'(memwb_bubble), 32'(e_mwb));
        check("md_start", 32'(md_start), 32'(e_start));
        check("md_done", 32'(md_done), 32'(e_done));
        check("mem_timeout_err", 32'(mem_timeout_err), 32'(m_err));
        check("stall_cycles", 32'(stall_cycles), 32'(m_stall));
        n_run   = frz ? ((m_run < TMO) ? m_run + 1 : m_run) : 0;
        n_err   = m_err || (n_run >= TMO);
        n_stall = (!e_pc && m_stall < STALL_MAX) ? m_stall + 1 : m_stall;
        n_active = m_active;
        n_age    = m_age;
        if (e_start) begin
            n_active = 1; n_age = 1;
        end else if (m_active) begin
            if (ready_now && !frz) n_active = 0;
            else if (m_age < MDC) n_age = m_age + 1;
        end
    end

    always @(posedge clk) begin
        if (arst_n) begin
            m_active = n_active; m_age = n_age; m_run = n_run;
            m_err = n_err; m_stall = n_stall;
        end
    end

    task automatic idle();
        id_rs1 = 0; id_rs2 = 0; id_uses_rs2 = 0; ex_rd = 0; ex_mem_read = 0;
        ex_muldiv = 0; branch_taken_ex = 0; mem_access = 0; dmem_ready = 0;
    endtask

    task automatic at_mid();
        @(negedge clk); #1;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic set_load_use();
        ex_mem_read = 1; ex_rd = 5; id_rs1 = 3; id_rs2 = 5; id_uses_rs2 = 1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        idle();
        arst_n = 0;
        at_mid();
        check("reset pc_we", 32'(pc_write_en), 1);
        check("reset exmem_we", 32'(exmem_write_en), 1);
        check("reset md_start", 32'(md_start), 0);
        check("reset stall", 32'(stall_cycles), 0);
        @(posedge clk); #2; arst_n = 1;
        step();

        // Load-use via rs2
        set_load_use();
        at_mid();
        check("lu pc_we", 32'(pc_write_en), 0);
        check("lu ifid_we", 32'(ifid_write_en), 0);
        check("lu idex_bubble", 32'(idex_bubble), 1);
        step();
        idle();
        at_mid();
        check("lu stall count", 32'(stall_cycles), 1);
        check("lu released", 32'(pc_write_en), 1);
        step();
        // Load to x0 never stalls
        ex_mem_read = 1; ex_rd = 0; id_rs1 = 0;
        at_mid();
        check("x0 no stall", 32'(pc_write_en), 1);
        step();
        // rs2 match ignored when rs2 is unused
        ex_rd = 7; id_rs1 = 1; id_rs2 = 7; id_uses_rs2 = 0;
        at_mid();
        check("rs2 unused", 32'(idex_bubble), 0);
        step();
        idle();

        // Mul/div occupancy
        ex_muldiv = 1;
        for (int k = 0; k <= MDC; k++) begin
            at_mid();
            if (k == 0) begin
                check("md t start", 32'(md_start), 1);
                check("md t exb", 32'(exmem_bubble), 1);
            end
            if (k == 1) check("md t+1 start", 32'(md_start), 0);
            if (k == MDC - 1) check("md t+7 exb", 32'(exmem_bubble), 1);
            if (k == MDC) begin
                check("md t+8 done", 32'(md_done), 1);
                check("md t+8 pc_we", 32'(pc_write_en), 1);
                check("md t+8 exb", 32'(exmem_bubble), 0);
            end
            step();
        end
        ex_muldiv = 0;
        at_mid();
        check("md after done", 32'(md_done), 0);
        check("md stall count", 32'(stall_cycles), 9);
        step();

        // Freeze exactly when the countdown reaches zero
        ex_muldiv = 1;
        for (int k = 0; k < MDC; k++) step();
        mem_access = 1; dmem_ready = 0;
        for (int k = 0; k < 3; k++) begin
            at_mid();
            check("mdf done held", 32'(md_done), 1);
            check("mdf memwb", 32'(memwb_bubble), 1);
            step();
        end
        dmem_ready = 1;
        at_mid();
        check("mdf release done", 32'(md_done), 1);
        check("mdf release pc", 32'(pc_write_en), 1);
        step();
        ex_muldiv = 0; mem_access = 0;
        at_mid();
        check("mdf back to run", 32'(md_done), 0);
        check("stall saturated", 32'(stall_cycles), STALL_MAX);
        step();

        // Branch + load-use + freeze together
        set_load_use();
        branch_taken_ex = 1; mem_access = 1; dmem_ready = 0;
        for (int k = 0; k < 2; k++) begin
            at_mid();
            check("bf frozen pc", 32'(pc_write_en), 0);
            check("bf frozen flush", 32'(ifid_flush), 0);
            check("bf frozen idb", 32'(idex_bubble), 0);
            step();
        end
        dmem_ready = 1;
        at_mid();
        check("bf flush", 32'(ifid_flush), 1);
        check("bf idb", 32'(idex_bubble), 1);
        check("bf pc", 32'(pc_write_en), 1);
        step();
        idle();
        step();

        // Asynchronous reset in the middle of a mul/div
        ex_muldiv = 1;
        for (int k = 0; k < 5; k++) step();
        #1;
        arst_n = 0; ex_muldiv = 0;
        #1;
        check("rst mid pc_we", 32'(pc_write_en), 1);
        check("rst mid idex_we", 32'(idex_write_en), 1);
        check("rst mid exb", 32'(exmem_bubble), 0);
        check("rst mid stall", 32'(stall_cycles), 0);
        step();
        #1; arst_n = 1;
        at_mid();
        step();

        // Watchdog
        mem_access = 1; dmem_ready = 0;
        for (int k = 1; k <= 6; k++) begin
            at_mid();
            if (k == 4) check("wd before", 32'(mem_timeout_err), 0);
            if (k == 5) check("wd rise", 32'(mem_timeout_err), 1);
            step();
        end
        dmem_ready = 1;
        at_mid();
        check("wd sticky", 32'(mem_timeout_err), 1);
        step();
        idle();
        at_mid();
        check("wd sticky idle", 32'(mem_timeout_err), 1);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
